// File: rtl/fpu_accum16_pkg.sv
// Shared FP16 accumulator types, widths and the fixed-point conversion helper.
package fpu_accum16_pkg;

    localparam int unsigned LEN_W = 8;
    // Any FP16 magnitude is an integer multiple of 2^-24 below 2^41; one extra bit holds the sign.
    localparam int unsigned FIX_W = 42;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

    // z: result is zero, c: result inexact, n: result sign, v: finite operands overflowed.
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef enum logic {
        FPU_ADD,
        FPU_SUB
    } fpuOp_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } accState_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    // Exact two's-complement fixed-point image of a finite FP16 value, in units of 2^-24.
    function automatic logic [FIX_W-1:0] fp16_to_fixed(input fp16_t x, input logic neg);
        logic [FIX_W-1:0] mag;
        if (x.exp == 5'd0) begin
            mag = FIX_W'(x.mant);
        end else begin
            mag = FIX_W'({1'b1, x.mant}) << (x.exp - 5'd1);
        end
        return neg ? (~mag + FIX_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/fpu_accum16_addsub.sv
// Combinational FP16 add/subtract, round-to-nearest-even, via exact fixed-point sum.
module fpuAddSub16
    import fpu_accum16_pkg::*;
(
    input  fp16_t     fpuIn1,
    input  fp16_t     fpuIn2,
    input  logic      sub,
    input  fpuOp_t    op,
    output fp16_t     fpuOut,
    output condCode_t condCodes
);

    logic             neg_b;
    logic             sign_a;
    logic             sign_b;
    logic             a_nan;
    logic             b_nan;
    logic             a_inf;
    logic             b_inf;
    logic [FIX_W-1:0] sum;
    logic             sum_neg;
    logic [FIX_W-1:0] mag;
    logic [5:0]       lead;
    logic [5:0]       sh;
    logic [10:0]      kept;
    logic [FIX_W-1:0] rem;
    logic [FIX_W-1:0] half;
    logic             round_up;
    logic [11:0]      sig;
    logic [5:0]       exp_w;
    logic [15:0]      res;

    // Align both operands exactly, add, then renormalise and round the magnitude.
    always_comb begin
        res       = '0;
        condCodes = '0;
        neg_b     = sub | (op == FPU_SUB);
        sign_a    = fpuIn1.sign;
        sign_b    = fpuIn2.sign ^ neg_b;
        a_nan     = (&fpuIn1.exp) && (fpuIn1.mant != 10'd0);
        b_nan     = (&fpuIn2.exp) && (fpuIn2.mant != 10'd0);
        a_inf     = (&fpuIn1.exp) && (fpuIn1.mant == 10'd0);
        b_inf     = (&fpuIn2.exp) && (fpuIn2.mant == 10'd0);
        sum       = fp16_to_fixed(fpuIn1, sign_a) + fp16_to_fixed(fpuIn2, sign_b);
        sum_neg   = sum[FIX_W-1];
        mag       = sum_neg ? (~sum + FIX_W'(1)) : sum;
        lead      = '0;
        for (int i = 0; i < FIX_W; i++) begin
            if (mag[i]) lead = 6'(i);
        end
        sh        = lead - 6'd10;
        kept      = 11'(mag >> sh);
        rem       = mag & ~({FIX_W{1'b1}} << sh);
        half      = (FIX_W'(1) << sh) >> 1;
        round_up  = (rem != '0) && ((rem > half) || ((rem == half) && kept[0]));
        sig       = {1'b0, kept} + 12'(round_up);
        exp_w     = lead - 6'd9 + 6'(sig[11]);

        if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
            res = FP16_QNAN;
        end else if (a_inf) begin
            res         = {sign_a, 5'h1F, 10'h000};
            condCodes.n = sign_a;
        end else if (b_inf) begin
            res         = {sign_b, 5'h1F, 10'h000};
            condCodes.n = sign_b;
        end else if (mag == '0) begin
            res         = {sign_a & sign_b, 15'h0000};
            condCodes.z = 1'b1;
            condCodes.n = sign_a & sign_b;
        end else if (lead < 6'd10) begin
            res         = {sum_neg, 5'h00, mag[9:0]};
            condCodes.n = sum_neg;
        end else if (exp_w >= 6'd31) begin
            res         = {sum_neg, 5'h1F, 10'h000};
            condCodes.c = 1'b1;
            condCodes.n = sum_neg;
            condCodes.v = 1'b1;
        end else begin
            res         = {sum_neg, exp_w[4:0], 10'(sig >> sig[11])};
            condCodes.c = (rem != '0);
            condCodes.n = sum_neg;
        end
        fpuOut = fp16_t'(res);
    end

endmodule

// File: rtl/fpu_accum16.sv
// Run-length-controlled FP16 accumulator: one sample per handshake, single-cycle update.
module fpu_accum16
    import fpu_accum16_pkg::*;
(
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             inValid,
    output logic             inReady,
    input  fp16_t            inData,
    input  logic             inSub,
    output fp16_t            accOut,
    output condCode_t        accCondCodes,
    output logic             stickyV,
    output logic [LEN_W-1:0] remaining,
    output logic             busy,
    output logic             done
);

    accState_t        state_q, state_d;
    fp16_t            acc_q, acc_d;
    condCode_t        cc_q, cc_d;
    logic             sticky_q, sticky_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ready_q, busy_q, done_q;
    logic             handshake;
    fp16_t            fpu_out;
    condCode_t        fpu_cc;

    assign handshake = inValid && ready_q;

    fpuAddSub16 u_addsub (
        .fpuIn1    (acc_q),
        .fpuIn2    (inData),
        .sub       (inSub),
        .op        (inSub ? FPU_SUB : FPU_ADD),
        .fpuOut    (fpu_out),
        .condCodes (fpu_cc)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cc_d     = cc_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d    = '0;
                    cc_d     = '{z: 1'b1, c: 1'b0, n: 1'b0, v: 1'b0};
                    sticky_d = 1'b0;
                    rem_d    = len;
                    state_d  = (len != '0) ? ACCUM : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (handshake) begin
                    acc_d    = fpu_out;
                    cc_d     = fpu_cc;
                    sticky_d = sticky_q | fpu_cc.v;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cc_q     <= '0;
            sticky_q <= 1'b0;
            rem_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cc_q     <= cc_d;
            sticky_q <= sticky_d;
            rem_q    <= rem_d;
            ready_q  <= (state_d == ACCUM);
            busy_q   <= (state_d == ACCUM);
            done_q   <= (state_d == DONE);
        end
    end

    assign inReady      = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign accOut       = acc_q;
    assign accCondCodes = cc_q;
    assign stickyV      = sticky_q;
    assign remaining    = rem_q;

endmodule
